// File: rtl/csrng_pkg.sv
// csrng_pkg: shared types for the CSRNG counter sequencer.
// The FSM state encoding is sparse (pairwise Hamming distance >= 3) so that a
// single upset lands on an illegal code, which the sequencer treats as Error.
package csrng_pkg;

    localparam int unsigned CtrStateW = 6;

    typedef enum logic [CtrStateW-1:0] {
        CtrIdle  = 6'b000000,
        CtrIssue = 6'b000111,
        CtrWait  = 6'b111000,
        CtrDone  = 6'b011011,
        CtrError = 6'b101101
    } ctr_state_e;

endpackage

// File: rtl/csrng_ctr_outbuf.sv
// csrng_ctr_outbuf: one-entry registered genbits buffer.
// Used by csrng_ctr_sequencer only when CALIPTRA_CSRNG_CTRSEQ_OUTBUF_EN is defined.
// A push into a full buffer is only legal in the same cycle the entry pops;
// the sequencer guarantees that through its benc_rdy_o gating.
module csrng_ctr_outbuf #(
    parameter int BlkLen  = 128,
    parameter int StateId = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [BlkLen-1:0]  data_i,
    input  logic [StateId-1:0] id_i,
    input  logic               rdy_i,
    output logic               vld_o,
    output logic [BlkLen-1:0]  data_o,
    output logic [StateId-1:0] id_o,
    output logic               empty_o
);

    logic               vld_q, vld_d;
    logic [BlkLen-1:0]  data_q, data_d;
    logic [StateId-1:0] id_q, id_d;

    // Next-state: pop on a consumed beat, then a push (if any) overrides.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        id_d   = id_q;
        if (vld_q && rdy_i) begin
            vld_d  = 1'b0;
            data_d = '0;
            id_d   = '0;
        end
        if (push_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
            id_d   = id_i;
        end
    end

    // Buffer register; reset or disable empties it.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            id_q   <= id_d;
        end
    end

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign id_o    = id_q;
    assign empty_o = !vld_q;

endmodule

// File: rtl/csrng_ctr_sequencer.sv
// csrng_ctr_sequencer: CTR-mode block sequencer for CSRNG generate commands.
// Takes one command (key, V, block count), issues nblk counter-incremented V
// blocks to the block-encrypt stage and streams the encrypted results out.
// Optional feature macro: CALIPTRA_CSRNG_CTRSEQ_OUTBUF_EN adds a registered
// one-entry genbits buffer; without it the result path is combinational.
//
// Handshakes: a transfer happens on a rising edge where valid/req and
// ready are both high; a raised request holds its payload until accepted.
// benc_ack_i is only asserted while benc_rdy_o is high.
module csrng_ctr_sequencer
    import csrng_pkg::*;
#(
    parameter int Cmd     = 3,
    parameter int StateId = 4,
    parameter int BlkLen  = 128,
    parameter int KeyLen  = 256,
    parameter int CtrLen  = 32,
    parameter int NumBlkW = 13
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 req_i,
    output logic                 rdy_o,
    input  logic [KeyLen-1:0]    key_i,
    input  logic [BlkLen-1:0]    v_i,
    input  logic [Cmd-1:0]       cmd_i,
    input  logic [StateId-1:0]   id_i,
    input  logic [NumBlkW-1:0]   nblk_i,
    output logic                 benc_req_o,
    input  logic                 benc_rdy_i,
    output logic [KeyLen-1:0]    benc_key_o,
    output logic [BlkLen-1:0]    benc_v_o,
    output logic [Cmd-1:0]       benc_cmd_o,
    output logic [StateId-1:0]   benc_id_o,
    input  logic                 benc_ack_i,
    output logic                 benc_rdy_o,
    input  logic [BlkLen-1:0]    benc_v_i,
    input  logic [Cmd-1:0]       benc_cmd_i,
    input  logic [StateId-1:0]   benc_id_i,
    output logic                 genbits_vld_o,
    input  logic                 genbits_rdy_i,
    output logic [BlkLen-1:0]    genbits_o,
    output logic [StateId-1:0]   genbits_id_o,
    output logic                 done_o,
    output logic [BlkLen-1:0]    done_v_o,
    output logic [StateId-1:0]   done_id_o,
    output logic                 err_o,
    output logic [CtrStateW-1:0] dbg_state_o
);

`ifdef CALIPTRA_CSRNG_CTRSEQ_OUTBUF_EN
    localparam bit HasOutBuf = 1'b1;
`else
    localparam bit HasOutBuf = 1'b0;
`endif

    ctr_state_e         state_q, state_d;
    logic [KeyLen-1:0]  key_q, key_d;
    logic [BlkLen-1:0]  v_q, v_d;
    logic [Cmd-1:0]     cmd_q, cmd_d;
    logic [StateId-1:0] id_q, id_d;
    logic [NumBlkW-1:0] rem_q, rem_d;

    logic              accept;
    logic              push;
    logic              sink_rdy;
    logic              buf_empty;
    logic [BlkLen-1:0] v_src;
    logic [BlkLen-1:0] v_inc;

    assign accept = req_i && enable_i && !rst_i;

    // Counter step: only the low CtrLen bits wrap, the rest of V is untouched.
    always_comb begin
        v_inc = {v_src[BlkLen-1:CtrLen], v_src[CtrLen-1:0] + CtrLen'(1)};
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        v_d        = v_q;
        cmd_d      = cmd_q;
        id_d       = id_q;
        rem_d      = rem_q;
        v_src      = v_q;
        rdy_o      = 1'b0;
        benc_req_o = 1'b0;
        benc_rdy_o = 1'b0;
        push       = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state_q)
            CtrIdle: begin
                rdy_o = enable_i && !rst_i;
                v_src = v_i;
                if (accept) begin
                    key_d = key_i;
                    cmd_d = cmd_i;
                    id_d  = id_i;
                    rem_d = nblk_i;
                    if (nblk_i == '0) begin
                        v_d     = v_i;
                        state_d = CtrDone;
                    end else begin
                        v_d     = v_inc;
                        state_d = CtrIssue;
                    end
                end
            end
            CtrIssue: begin
                benc_req_o = 1'b1;
                if (benc_rdy_i) state_d = CtrWait;
            end
            CtrWait: begin
                // rem_q == 0 here only while the output buffer drains.
                benc_rdy_o = (rem_q != '0) && sink_rdy;
                if (rem_q == '0) begin
                    if (buf_empty) state_d = CtrDone;
                end else if (benc_ack_i) begin
                    if ((benc_id_i != id_q) || (benc_cmd_i != cmd_q)) begin
                        state_d = CtrError;
                    end else begin
                        push  = 1'b1;
                        rem_d = rem_q - NumBlkW'(1);
                        if (rem_q == NumBlkW'(1)) begin
                            state_d = HasOutBuf ? CtrWait : CtrDone;
                        end else begin
                            v_d     = v_inc;
                            state_d = CtrIssue;
                        end
                    end
                end
            end
            CtrDone: begin
                done_o  = 1'b1;
                state_d = CtrIdle;
            end
            CtrError: begin
                err_o = 1'b1;
            end
            default: begin
                state_d = CtrError;
            end
        endcase
    end

    // State and command registers; disable behaves like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            state_q <= CtrIdle;
            key_q   <= '0;
            v_q     <= '0;
            cmd_q   <= '0;
            id_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            v_q     <= v_d;
            cmd_q   <= cmd_d;
            id_q    <= id_d;
            rem_q   <= rem_d;
        end
    end

    assign benc_key_o  = key_q;
    assign benc_v_o    = v_q;
    assign benc_cmd_o  = cmd_q;
    assign benc_id_o   = id_q;
    assign done_v_o    = done_o ? v_q : '0;
    assign done_id_o   = done_o ? id_q : '0;
    assign dbg_state_o = state_q;

`ifdef CALIPTRA_CSRNG_CTRSEQ_OUTBUF_EN
    csrng_ctr_outbuf #(
        .BlkLen  (BlkLen),
        .StateId (StateId)
    ) u_outbuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!enable_i),
        .push_i  (push),
        .data_i  (benc_v_i),
        .id_i    (id_q),
        .rdy_i   (genbits_rdy_i),
        .vld_o   (genbits_vld_o),
        .data_o  (genbits_o),
        .id_o    (genbits_id_o),
        .empty_o (buf_empty)
    );
    assign sink_rdy = buf_empty || genbits_rdy_i;
`else
    // Pass-through: a result is only accepted when the consumer can take it.
    assign buf_empty     = 1'b1;
    assign sink_rdy      = genbits_rdy_i;
    assign genbits_vld_o = push;
    assign genbits_o     = push ? benc_v_i : '0;
    assign genbits_id_o  = push ? id_q : '0;
`endif

endmodule

// File: tb/tb_csrng_ctr_sequencer.sv
// tb_csrng_ctr_sequencer: self-checking bench for csrng_ctr_sequencer.
// Works with and without CALIPTRA_CSRNG_CTRSEQ_OUTBUF_EN.
module tb_csrng_ctr_sequencer;
    import csrng_pkg::*;

    localparam int Cmd     = 3;
    localparam int StateId = 4;
    localparam int BlkLen  = 128;
    localparam int KeyLen  = 256;
    localparam int CtrLen  = 32;
    localparam int NumBlkW = 13;

`ifdef CALIPTRA_CSRNG_CTRSEQ_OUTBUF_EN
    localparam bit OutBuf = 1'b1;
`else
    localparam bit OutBuf = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                 rst_i = 1'b1;
    logic                 enable_i = 1'b1;
    logic                 req_i = 1'b0;
    logic                 rdy_o;
    logic [KeyLen-1:0]    key_i = '0;
    logic [BlkLen-1:0]    v_i = '0;
    logic [Cmd-1:0]       cmd_i = '0;
    logic [StateId-1:0]   id_i = '0;
    logic [NumBlkW-1:0]   nblk_i = '0;
    logic                 benc_req_o;
    logic                 benc_rdy_i = 1'b1;
    logic [KeyLen-1:0]    benc_key_o;
    logic [BlkLen-1:0]    benc_v_o;
    logic [Cmd-1:0]       benc_cmd_o;
    logic [StateId-1:0]   benc_id_o;
    logic                 benc_ack_i = 1'b0;
    logic                 benc_rdy_o;
    logic [BlkLen-1:0]    benc_v_i = '0;
    logic [Cmd-1:0]       benc_cmd_i = '0;
    logic [StateId-1:0]   benc_id_i = '0;
    logic                 genbits_vld_o;
    logic                 genbits_rdy_i = 1'b1;
    logic [BlkLen-1:0]    genbits_o;
    logic [StateId-1:0]   genbits_id_o;
    logic                 done_o;
    logic [BlkLen-1:0]    done_v_o;
    logic [StateId-1:0]   done_id_o;
    logic                 err_o;
    logic [CtrStateW-1:0] dbg_state_o;

    csrng_ctr_sequencer #(
        .Cmd(Cmd), .StateId(StateId), .BlkLen(BlkLen),
        .KeyLen(KeyLen), .CtrLen(CtrLen), .NumBlkW(NumBlkW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .req_i(req_i), .rdy_o(rdy_o),
        .key_i(key_i), .v_i(v_i), .cmd_i(cmd_i), .id_i(id_i), .nblk_i(nblk_i),
        .benc_req_o(benc_req_o), .benc_rdy_i(benc_rdy_i),
        .benc_key_o(benc_key_o), .benc_v_o(benc_v_o),
        .benc_cmd_o(benc_cmd_o), .benc_id_o(benc_id_o),
        .benc_ack_i(benc_ack_i), .benc_rdy_o(benc_rdy_o),
        .benc_v_i(benc_v_i), .benc_cmd_i(benc_cmd_i), .benc_id_i(benc_id_i),
        .genbits_vld_o(genbits_vld_o), .genbits_rdy_i(genbits_rdy_i),
        .genbits_o(genbits_o), .genbits_id_o(genbits_id_o),
        .done_o(done_o), .done_v_o(done_v_o), .done_id_o(done_id_o),
        .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;

    logic [BlkLen-1:0] exp_q[$];   // expected genbits beats
    logic [BlkLen-1:0] pend_q[$];  // requests accepted by the encrypt model

    // Command descriptor published by the driver, picked up by the responder.
    int                 cmd_seq = 0;
    logic [BlkLen-1:0]  c_v = '0;
    logic [KeyLen-1:0]  c_key = '0;
    logic [Cmd-1:0]     c_cmd = '0;
    logic [StateId-1:0] c_id = '0;
    bit                 c_corrupt = 1'b0;
    int                 c_stall = -1;

    // Responder-owned model state.
    int                 seen_seq = 0;
    logic [BlkLen-1:0]  m_v = '0;
    bit                 corrupt_next = 1'b0;
    int                 stall_at = -1;
    int                 stall_left = 0;
    bit                 in_stall = 1'b0;
    bit                 req_hold = 1'b0;
    int                 beats_seen = 0;
    int                 reqs_seen = 0;
    int                 dones_seen = 0;
    logic [BlkLen-1:0]  last_done_v = '0;
    logic [BlkLen-1:0]  bfm_p;
    logic [BlkLen-1:0]  bfm_e;

    task automatic check_eq(input string tag, input logic [KeyLen-1:0] got,
                            input logic [KeyLen-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BlkLen-1:0] inc_v(input logic [BlkLen-1:0] x);
        return {x[BlkLen-1:CtrLen], x[CtrLen-1:0] + 32'd1};
    endfunction

    function automatic logic [BlkLen-1:0] enc(input logic [BlkLen-1:0] x);
        return {x[63:0], x[127:64]} ^ 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
    endfunction

    // ---------------- encrypt-stage model, sink and monitor ----------------
    always begin
        @(negedge clk_i);
        in_stall = 1'b0;
        if (cmd_seq != seen_seq) begin
            seen_seq     = cmd_seq;
            m_v          = c_v;
            corrupt_next = c_corrupt;
            stall_at     = (c_stall < 0) ? -1 : beats_seen + c_stall;
        end
        if (rst_i || !enable_i) begin
            pend_q.delete();
            exp_q.delete();
            benc_ack_i    = 1'b0;
            benc_v_i      = '0;
            benc_cmd_i    = '0;
            benc_id_i     = '0;
            genbits_rdy_i = 1'b1;
            benc_rdy_i    = 1'b1;
            stall_left    = 0;
            req_hold      = 1'b0;
        end else begin
            if (stall_at >= 0 && beats_seen == stall_at) begin
                stall_left = 10;
                stall_at   = -1;
            end
            if (stall_left > 0) begin
                genbits_rdy_i = 1'b0;
                stall_left--;
                in_stall = 1'b1;
            end else begin
                genbits_rdy_i = ($urandom_range(0, 4) != 0);
            end
            benc_rdy_i = ($urandom_range(0, 3) != 0);
            #1;
            if (benc_rdy_o && pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                bfm_p      = pend_q.pop_front();
                benc_ack_i = 1'b1;
                benc_v_i   = enc(bfm_p);
                benc_cmd_i = c_cmd;
                benc_id_i  = corrupt_next ? (c_id ^ 4'd1) : c_id;
                if (corrupt_next) corrupt_next = 1'b0;
                else exp_q.push_back(enc(bfm_p));
            end else begin
                benc_ack_i = 1'b0;
                benc_v_i   = '0;
            end
            #1;
            if (in_stall && (!OutBuf || genbits_vld_o))
                check_eq("stall_benc_rdy", benc_rdy_o, 1'b0);
            if (req_hold) check_eq("req_hold", benc_req_o, 1'b1);
            req_hold = benc_req_o && !benc_rdy_i;
            if (benc_req_o) begin
                check_eq("benc_v", benc_v_o, inc_v(m_v));
                check_eq("benc_key", benc_key_o, c_key);
                check_eq("benc_cmd", benc_cmd_o, c_cmd);
                check_eq("benc_id", benc_id_o, c_id);
                if (benc_rdy_i) begin
                    m_v = inc_v(m_v);
                    pend_q.push_back(m_v);
                    reqs_seen++;
                end
            end
            if (genbits_vld_o && genbits_rdy_i) begin
                check_eq("genbits_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    bfm_e = exp_q.pop_front();
                    check_eq("genbits", genbits_o, bfm_e);
                    check_eq("genbits_id", genbits_id_o, c_id);
                end
                beats_seen++;
            end
            if (done_o) begin
                dones_seen++;
                last_done_v = done_v_o;
                check_eq("done_v", done_v_o, m_v);
                check_eq("done_id", done_id_o, c_id);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input logic [KeyLen-1:0] key, input logic [BlkLen-1:0] v,
                             input logic [Cmd-1:0] cmd, input logic [StateId-1:0] id,
                             input int nblk, input bit corrupt, input int stall_beat);
        int n;
        @(posedge clk_i);
        #1;
        c_key = key; c_v = v; c_cmd = cmd; c_id = id;
        c_corrupt = corrupt; c_stall = stall_beat;
        cmd_seq++;
        key_i = key; v_i = v; cmd_i = cmd; id_i = id;
        nblk_i = NumBlkW'(nblk);
        req_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            #3;
            n++;
        end while (!rdy_o && n < 20);
        check_eq("accept_rdy", rdy_o, 1'b1);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        key_i = ~key; v_i = ~v; cmd_i = ~cmd; id_i = ~id; nblk_i = '1;
        @(negedge clk_i);
        #3;
        if (nblk == 0) begin
            check_eq("nblk0_done_lat", done_o, 1'b1);
            check_eq("nblk0_no_req", benc_req_o, 1'b0);
        end else begin
            check_eq("first_req_lat", benc_req_o, 1'b1);
        end
    endtask

    task automatic run_cmd(input logic [KeyLen-1:0] key, input logic [BlkLen-1:0] v,
                           input logic [Cmd-1:0] cmd, input logic [StateId-1:0] id,
                           input int nblk, input int stall_beat,
                           input logic [BlkLen-1:0] final_v);
        int d0, b0, r0, n;
        d0 = dones_seen; b0 = beats_seen; r0 = reqs_seen;
        start_cmd(key, v, cmd, id, nblk, 1'b0, stall_beat);
        n = 0;
        while (dones_seen == d0 && n < 3000) begin
            @(negedge clk_i);
            #3;
            n++;
        end
        check_eq("done_seen", dones_seen - d0, 1);
        check_eq("beats", beats_seen - b0, nblk);
        check_eq("reqs", reqs_seen - r0, nblk);
        check_eq("exp_drained", exp_q.size(), 0);
        check_eq("final_v", last_done_v, final_v);
        repeat (3) @(negedge clk_i);
        #3;
        check_eq("done_single", dones_seen - d0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, d0, b0;
        logic [BlkLen-1:0] rv;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #3;
        check_eq("rst_rdy", rdy_o, 1'b0);
        check_eq("rst_benc_req", benc_req_o, 1'b0);
        check_eq("rst_benc_rdy", benc_rdy_o, 1'b0);
        check_eq("rst_gb_vld", genbits_vld_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_benc_v", benc_v_o, '0);
        check_eq("rst_state", dbg_state_o, CtrIdle);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Basic three-block command from a small counter value.
        run_cmd({8{32'hA5A5_0001}}, {96'h1111_2222_3333_4444_5555_6666, 32'h0000_0005},
                3'd1, 4'd3, 3, -1,
                {96'h1111_2222_3333_4444_5555_6666, 32'h0000_0008});

        // Counter wrap: upper 96 bits must not carry.
        run_cmd({8{32'h0BAD_F00D}}, {96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 32'hFFFF_FFFF},
                3'd2, 4'd5, 2, -1,
                {96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 32'h0000_0001});

        // Zero-block command completes straight away with V unchanged.
        d0 = reqs_seen;
        run_cmd({8{32'h1357_9BDF}}, {4{32'hCAFE_0042}}, 3'd3, 4'd7, 0, -1,
                {4{32'hCAFE_0042}});
        check_eq("nblk0_reqs", reqs_seen - d0, 0);

        // Consumer stalls for 10 cycles after the second beat.
        run_cmd({8{32'h2468_ACE0}}, {4{32'h7777_0100}}, 3'd4, 4'd9, 4, 2,
                {{3{32'h7777_0100}}, 32'h7777_0104});

        // Tag mismatch on the first result.
        d0 = dones_seen; b0 = beats_seen;
        start_cmd({8{32'hDEAD_BEEF}}, {4{32'h0000_1000}}, 3'd5, 4'd6, 2, 1'b1, -1);
        n = 0;
        while (!err_o && n < 200) begin
            @(negedge clk_i);
            #3;
            n++;
        end
        check_eq("err_set", err_o, 1'b1);
        repeat (4) @(negedge clk_i);
        #3;
        check_eq("err_sticky", err_o, 1'b1);
        check_eq("err_no_rdy", rdy_o, 1'b0);
        check_eq("err_no_req", benc_req_o, 1'b0);
        check_eq("err_no_benc_rdy", benc_rdy_o, 1'b0);
        check_eq("err_no_gb", genbits_vld_o, 1'b0);
        check_eq("err_beats", beats_seen - b0, 0);
        check_eq("err_dones", dones_seen - d0, 0);
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #3;
        check_eq("dis_err_clr", err_o, 1'b0);
        check_eq("dis_state", dbg_state_o, CtrIdle);
        @(posedge clk_i);
        #1;
        enable_i = 1'b1;

        // Reset in the middle of a five-block command.
        d0 = dones_seen; b0 = beats_seen;
        start_cmd({8{32'h5555_AAAA}}, {4{32'h0102_0300}}, 3'd6, 4'd11, 5, 1'b0, -1);
        n = 0;
        while (!((beats_seen - b0) >= 2 && dbg_state_o == CtrWait) && n < 2000) begin
            @(negedge clk_i);
            #3;
            n++;
        end
        check_eq("rst_mid_wait", dbg_state_o, CtrWait);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        #3;
        check_eq("mrst_rdy", rdy_o, 1'b0);
        check_eq("mrst_benc_req", benc_req_o, 1'b0);
        check_eq("mrst_benc_rdy", benc_rdy_o, 1'b0);
        check_eq("mrst_gb_vld", genbits_vld_o, 1'b0);
        check_eq("mrst_done", done_o, 1'b0);
        check_eq("mrst_err", err_o, 1'b0);
        check_eq("mrst_benc_v", benc_v_o, '0);
        check_eq("mrst_benc_key", benc_key_o, '0);
        check_eq("mrst_gb", genbits_o, '0);
        check_eq("mrst_done_v", done_v_o, '0);
        check_eq("mrst_state", dbg_state_o, CtrIdle);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #3;
        check_eq("mrst_no_done", dones_seen - d0, 0);

        // Fresh command after the abandoned one.
        rv = {$urandom, $urandom, $urandom, 32'h0000_0010};
        run_cmd({8{$urandom}}, rv, 3'd7, 4'd2, 3, -1, inc_v(inc_v(inc_v(rv))));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
